memcard_responder: RTL

- Card-side end of the SD/MMC CMD-line protocol. It samples the host-driven mc_clk and mc_cmd, deframes 48-bit command tokens, and hands each decoded command to local logic.
- It then serialises the 48-bit response that local logic supplies.
- Used as an on-chip card model for host-controller verification, and as the command front-end of an FPGA card emulator.
- All logic runs in sys_clk; mc_clk is oversampled and is never used as a clock.

---
 rtl/memcard_pkg.sv | 15 +
 rtl/memcard_crc7.sv | 20 ++
 rtl/memcard_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/memcard_pkg.sv
// memcard_pkg: shared types and token geometry for the memcard responder.
// Contents: state_t (IDLE, RX, CMD, TX_WAIT, TX), token sizes, CRC7 polynomial,
// and the bit positions of each field inside a 48-bit CMD-line token
// (position 47 is the start bit, position 0 the end bit).
package memcard_pkg;
    typedef enum logic [2:0] {IDLE, RX, CMD, TX_WAIT, TX} state_t;
    localparam int TOKEN_BITS = 48;
    localparam int PAYLOAD_BITS = 40;
    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam int TRANS_POS = 46;
    localparam int IDX_MSB = 45;
    localparam int IDX_LSB = 40;
    localparam int ARG_MSB = 39;
    localparam int ARG_LSB = 8;
endpackage

// File: rtl/memcard_crc7.sv
// memcard_crc7: serial CRC7 (x^7+x^3+1, init 0, MSB first).
// Ports: sys_clk/sys_rst (sync, active-low) clock and reset; clear zeroes the
// remainder (when ce is also high the bit is fed into the zeroed remainder);
// ce advances one bit; din is the data bit; crc is the running remainder.
module memcard_crc7
    import memcard_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       clear,
    input  logic       ce,
    input  logic       din,
    output logic [6:0] crc
);
    logic [6:0] base;
    assign base = clear ? 7'd0 : crc;
    always_ff @(posedge sys_clk)
        if (!sys_rst) crc <= '0;
        else if (clear || ce) crc <= ce ? ({base[5:0], 1'b0} ^ ({7{din ^ base[6]}} & CRC7_POLY)) : 7'd0;
endmodule

// File: rtl/memcard_responder.sv
// memcard_responder: card-side SD/MMC CMD-line deframer and response serialiser.
// Ports: sys_clk/sys_rst (sync, active-low); mc_clk/mc_cmd_i host clock and CMD
// line (oversampled, never used as a clock); mc_cmd_o/mc_cmd_oe CMD drive value
// and enable; cmd_valid/cmd_index/cmd_arg/cmd_crc_ok/cmd_frame_ok decoded command;
// cmd_ack drops it unanswered; resp_valid/resp_index/resp_arg/resp_ready response
// handshake; busy is high outside IDLE.
// Build option MEMCARD_RESPONDER_CRC_CHECK_EN: when defined the received CRC7 is
// checked; otherwise the CRC field is discarded and cmd_crc_ok is tied to 1.
module memcard_responder
    import memcard_pkg::*;
#(
    parameter int NCR = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        mc_clk,
    input  logic        mc_cmd_i,
    output logic        mc_cmd_o,
    output logic        mc_cmd_oe,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_crc_ok,
    output logic        cmd_frame_ok,
    input  logic        cmd_ack,
    input  logic        resp_valid,
    input  logic [5:0]  resp_index,
    input  logic [31:0] resp_arg,
    output logic        resp_ready,
    output logic        busy
);
    logic [SYNC_STAGES-1:0] clk_sync, cmd_sync;
    logic clk_d, rise, fall, cmd_bit;
    state_t state, state_n;
    logic [5:0] bit_cnt, ncr_cnt;
    logic [TRANS_POS-ARG_LSB:0] rx_sr;
    logic [PAYLOAD_BITS-1:0] tx_sr;
    logic [6:0] tx_crc;
    logic [2:0] crc_sel;
    logic start, rx_take, rx_end, accept, drive, tx_done, tx_bit, payload;

    assign rise = clk_sync[SYNC_STAGES-1] & ~clk_d;
    assign fall = ~clk_sync[SYNC_STAGES-1] & clk_d;
    assign cmd_bit = cmd_sync[SYNC_STAGES-1];
    assign payload = bit_cnt < 6'(PAYLOAD_BITS);
    // CRC bits travel MSB first at token bits 40..46
    assign crc_sel = 3'(6'(TOKEN_BITS - 2) - bit_cnt);
    assign tx_bit = payload ? tx_sr[PAYLOAD_BITS-1] : bit_cnt < 6'(TOKEN_BITS - 1) ? tx_crc[crc_sel] : 1'b1;
    assign resp_ready = sys_rst && accept;
    assign busy = state != IDLE;

    always_comb begin
        start = state == IDLE && rise && !cmd_bit;
        rx_take = state == RX && rise;
        rx_end = rx_take && bit_cnt == 6'(TOKEN_BITS - 1);
        accept = state == CMD && resp_valid;
        drive = fall && (state == TX_WAIT ? ncr_cnt >= 6'(NCR - 1) : state == TX && bit_cnt != 6'(TOKEN_BITS));
        tx_done = state == TX && fall && bit_cnt == 6'(TOKEN_BITS);
        state_n = state;
        case (state)
            IDLE:    state_n = start ? RX : IDLE;
            RX:      state_n = rx_end ? CMD : RX;
            CMD:     state_n = resp_valid ? TX_WAIT : cmd_ack ? IDLE : CMD;
            TX_WAIT: state_n = drive ? TX : TX_WAIT;
            TX:      state_n = tx_done ? IDLE : TX;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk)
        if (!sys_rst) begin
            clk_sync <= '0;
            cmd_sync <= '1;
            clk_d <= 1'b0;
            state <= IDLE;
            bit_cnt <= '0;
            ncr_cnt <= '0;
            rx_sr <= '0;
            tx_sr <= '0;
            cmd_valid <= 1'b0;
            cmd_index <= '0;
            cmd_arg <= '0;
            cmd_frame_ok <= 1'b0;
            mc_cmd_oe <= 1'b0;
            mc_cmd_o <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], mc_clk};
            cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], mc_cmd_i};
            clk_d <= clk_sync[SYNC_STAGES-1];
            state <= state_n;
            if (start) bit_cnt <= 6'd1;
            else if (rx_take || drive) bit_cnt <= bit_cnt + 6'd1;
            else if (accept) bit_cnt <= '0;
            // only bits 1..39 are kept; the start bit falls off the top
            if (start || (rx_take && payload)) rx_sr <= {rx_sr[TRANS_POS-ARG_LSB-1:0], cmd_bit};
            if (rx_end) begin
                ncr_cnt <= '0;
                cmd_valid <= 1'b1;
                cmd_index <= rx_sr[IDX_MSB-ARG_LSB -: IDX_MSB-IDX_LSB+1];
                cmd_arg <= rx_sr[ARG_MSB-ARG_LSB:0];
                cmd_frame_ok <= rx_sr[TRANS_POS-ARG_LSB] & cmd_bit;
            end else if ((state == CMD || state == TX_WAIT) && fall && ncr_cnt != 6'd63)
                ncr_cnt <= ncr_cnt + 6'd1;
            if (state == CMD && (resp_valid || cmd_ack)) cmd_valid <= 1'b0;
            if (accept) tx_sr <= {2'b00, resp_index, resp_arg};
            else if (drive && payload) tx_sr <= {tx_sr[PAYLOAD_BITS-2:0], 1'b0};
            if (drive) begin
                mc_cmd_oe <= 1'b1;
                mc_cmd_o <= tx_bit;
            end else if (tx_done) begin
                mc_cmd_oe <= 1'b0;
                mc_cmd_o <= 1'b1;
            end
        end

    memcard_crc7 u_tx_crc (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .clear(accept),
        .ce(drive && payload),
        .din(tx_bit),
        .crc(tx_crc)
    );

`ifdef MEMCARD_RESPONDER_CRC_CHECK_EN
    logic [6:0] rx_crc;
    logic crc_err;
    memcard_crc7 u_rx_crc (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .clear(state == IDLE),
        .ce(start || (rx_take && payload)),
        .din(cmd_bit),
        .crc(rx_crc)
    );
    // received CRC bits are compared serially as they arrive
    always_ff @(posedge sys_clk)
        if (!sys_rst) begin
            crc_err <= 1'b0;
            cmd_crc_ok <= 1'b0;
        end else begin
            if (start) crc_err <= 1'b0;
            else if (rx_take && !payload && !rx_end && cmd_bit != rx_crc[crc_sel]) crc_err <= 1'b1;
            if (rx_end) cmd_crc_ok <= !crc_err;
        end
`else
    assign cmd_crc_ok = 1'b1;
`endif
endmodule
